reg_wb_arb: RTL
===============

# reg_wb_arb

Write-back arbiter and hazard scoreboard for the 16 x 32-bit register file. It shares the register file's single write port (we/wa/wd) between two producers, the ALU result path and the load/memory return path. It buffers one pending result per producer and orders writes oldest-first. It keeps a per-register pending-write scoreboard that decode queries to stall on RAW hazards. It sits between the execute/memory stages and the register file; wa == 15 writes are flagged for the PC logic.

## Interface
- DW, 32, data width
- AW, 4, register address width
- NREG, 16, register count (2**AW)

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low (0 = reset)
- alu_valid / alu_ready  in / out  1 / 1  ALU write-back handshake
- alu_addr / alu_data  in  AW / DW  ALU destination, result
- mem_valid / mem_ready  in / out  1 / 1  memory write-back handshake
- mem_addr / mem_data  in  AW / DW  load destination, data
- claim_valid  in  1  decode reserves a destination register this cycle
- claim_addr  in  AW  register being reserved
- q1_addr, q2_addr  in  AW  decode source operands to check
- q1_busy, q2_busy  out  1  combinational: pending bit of q1_addr / q2_addr
- we  out  1  registered write enable to register file
- wa  out  AW  registered write address
- wd  out  DW  registered write data
- pc_wb  out  1  registered; equals we & (wa == 15)
- busy_mask  out  NREG  registered pending bits, bit i = register i

## Operation
- Per producer: one-entry buffer {full, addr, data, age}. The age is a 2-bit arrival stamp from a shared counter.
- Ready: x_ready = !x_full | x_grant. Combinational; low while reset is asserted.
- Accept: on an edge where x_valid & x_ready, load the buffer and set full.
- Drain: a granted buffer clears on the same edge unless it is refilled in the same cycle (accept + drain allowed).
- Grant, combinational, at most one per cycle:
  - only one buffer full -> grant it;
  - both full -> grant the older (smaller arrival order);
  - both accepted on the same edge (tie) -> grant per round-robin pointer rr, then flip rr.
  - rr resets to MEM.
- Ordering: two writes to the same address complete in arrival order. Ties go in rr order.
- Output stage: on the grant edge, load we=1, wa, wd from the granted buffer and pc_wb=(addr==15). With no grant, we=0 and pc_wb=0; wa and wd hold.
- Scoreboard, pending[NREG]:
  - Set on an edge where claim_valid (bit claim_addr).
  - Clear on an edge where we==1 (bit wa). This is the edge at which the register file commits.
  - Set and clear of the same bit on the same edge -> set wins.
  - Clearing an already-clear bit is a no-op.
  - q*_busy = pending[q*_addr]; busy_mask mirrors pending.
- No data forwarding. Decode must stall while q*_busy.

## Timing
- Reset (async assert): we=0, wa=0, wd=0, pc_wb=0, busy_mask=0, both buffers empty, rr=MEM, age counter=0, *_ready=0. On release, *_ready=1 combinationally.
- Latency:
  - Handshake at edge E0 -> buffer full.
  - Grant during the E0..E1 cycle -> we/wa/wd valid during E1..E2.
  - Register file writes at E2; pending bit clears at E2.
  - A write is visible to a register-file read issued at E2.
- Throughput: one write per cycle sustained. With both producers streaming, each gets one write every 2 cycles.
- Backpressure: x_ready drops only when x_full and not granted. A producer holding valid must keep addr/data stable until accepted.
- Reset mid-operation: buffered and in-flight results are discarded and pending bits cleared. Upstream must replay.

## Test plan
- Single ALU write: alu_valid, addr=3, data=0xDEADBEEF at E0 -> we=1, wa=3, wd=0xDEADBEEF during E1..E2; alu_ready stays 1.
- Simultaneous first requests after reset: ALU r1=0x11, MEM r2=0x22 on the same edge -> MEM write at E1, ALU write at E2. The next tie is granted to ALU first.
- Same-address ordering: MEM r5=0xA at E0, ALU r5=0xB at E1 -> writes occur in order 0xA then 0xB; final wd=0xB.
- Scoreboard: claim r7, q1_addr=7 -> q1_busy=1 until the edge where we writes r7, then 0. Claim and write of r7 on the same edge -> busy stays 1.
- Backpressure: both producers valid every cycle for 8 cycles -> 8 writes total, alternating, no drops; each ready deasserts on alternate cycles.
- PC write plus async reset: ALU r15=0x100 -> pc_wb=1 with we. Assert reset with both buffers full -> all outputs 0 immediately; no write occurs after release.

Source files
------------

// File: rtl/reg_wb_arb.sv
// reg_wb_arb: shares the register file write port between the ALU and
// load-return producers. One buffered result per producer, oldest-first
// grant with round-robin on same-edge ties, registered write port, and a
// per-register pending-write scoreboard for decode RAW stalls.
module reg_wb_arb #(
  parameter int DW   = 32,
  parameter int AW   = 4,
  parameter int NREG = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [AW-1:0]   alu_addr,
  input  logic [DW-1:0]   alu_data,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic [AW-1:0]   mem_addr,
  input  logic [DW-1:0]   mem_data,
  input  logic            claim_valid,
  input  logic [AW-1:0]   claim_addr,
  input  logic [AW-1:0]   q1_addr,
  input  logic [AW-1:0]   q2_addr,
  output logic            q1_busy,
  output logic            q2_busy,
  output logic            we,
  output logic [AW-1:0]   wa,
  output logic [DW-1:0]   wd,
  output logic            pc_wb,
  output logic [NREG-1:0] busy_mask
);

  localparam logic [AW-1:0] PC_REG = AW'(15);

  logic            alu_full_q, alu_full_d, mem_full_q, mem_full_d;
  logic [AW-1:0]   alu_addr_q, alu_addr_d, mem_addr_q, mem_addr_d;
  logic [DW-1:0]   alu_data_q, alu_data_d, mem_data_q, mem_data_d;
  logic [1:0]      alu_age_q, alu_age_d, mem_age_q, mem_age_d;
  logic [1:0]      age_cnt_q, age_cnt_d;
  logic            rr_alu_q, rr_alu_d;   // 1: ALU wins the next tie
  logic            we_q, we_d, pc_wb_q, pc_wb_d;
  logic [AW-1:0]   wa_q, wa_d;
  logic [DW-1:0]   wd_q, wd_d;
  logic [NREG-1:0] pending_q, pending_d;

  logic [1:0]      age_diff;
  logic            tie, alu_older, both_full;
  logic            alu_grant, mem_grant, any_grant;
  logic            alu_acc, mem_acc;
  logic [AW-1:0]   gnt_addr;
  logic [DW-1:0]   gnt_data;

  // Grant, handshake and next-state computation for buffers, output and scoreboard
  always_comb begin
    // At most two results are ever in flight, so stamps differ by at most one
    // step modulo 4; a forward distance of 1..2 means the ALU entry is older.
    age_diff  = mem_age_q - alu_age_q;
    tie       = (age_diff == 2'd0);
    alu_older = (age_diff == 2'd1) || (age_diff == 2'd2);
    both_full = alu_full_q & mem_full_q;

    alu_grant = alu_full_q & (!mem_full_q | (tie ? rr_alu_q : alu_older));
    mem_grant = mem_full_q & !alu_grant;
    any_grant = alu_grant | mem_grant;
    gnt_addr  = alu_grant ? alu_addr_q : mem_addr_q;
    gnt_data  = alu_grant ? alu_data_q : mem_data_q;

    alu_ready = reset & (!alu_full_q | alu_grant);
    mem_ready = reset & (!mem_full_q | mem_grant);
    alu_acc   = alu_valid & alu_ready;
    mem_acc   = mem_valid & mem_ready;

    alu_full_d = alu_acc | (alu_full_q & !alu_grant);
    alu_addr_d = alu_acc ? alu_addr  : alu_addr_q;
    alu_data_d = alu_acc ? alu_data  : alu_data_q;
    alu_age_d  = alu_acc ? age_cnt_q : alu_age_q;
    mem_full_d = mem_acc | (mem_full_q & !mem_grant);
    mem_addr_d = mem_acc ? mem_addr  : mem_addr_q;
    mem_data_d = mem_acc ? mem_data  : mem_data_q;
    mem_age_d  = mem_acc ? age_cnt_q : mem_age_q;

    // Same-edge acceptances share one stamp, which is what marks a tie.
    age_cnt_d = age_cnt_q + 2'(alu_acc | mem_acc);
    rr_alu_d  = rr_alu_q ^ (both_full & tie);

    we_d    = any_grant;
    wa_d    = any_grant ? gnt_addr : wa_q;
    wd_d    = any_grant ? gnt_data : wd_q;
    pc_wb_d = any_grant & (gnt_addr == PC_REG);

    // Clear on the commit edge first so a same-edge claim re-sets the bit.
    pending_d = pending_q;
    if (we_q)        pending_d[wa_q]       = 1'b0;
    if (claim_valid) pending_d[claim_addr] = 1'b1;
  end

  // All architectural state; reset discards buffered and in-flight writes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_full_q <= 1'b0;
      alu_addr_q <= '0;
      alu_data_q <= '0;
      alu_age_q  <= '0;
      mem_full_q <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_age_q  <= '0;
      age_cnt_q  <= '0;
      rr_alu_q   <= 1'b0;
      we_q       <= 1'b0;
      wa_q       <= '0;
      wd_q       <= '0;
      pc_wb_q    <= 1'b0;
      pending_q  <= '0;
    end else begin
      alu_full_q <= alu_full_d;
      alu_addr_q <= alu_addr_d;
      alu_data_q <= alu_data_d;
      alu_age_q  <= alu_age_d;
      mem_full_q <= mem_full_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_age_q  <= mem_age_d;
      age_cnt_q  <= age_cnt_d;
      rr_alu_q   <= rr_alu_d;
      we_q       <= we_d;
      wa_q       <= wa_d;
      wd_q       <= wd_d;
      pc_wb_q    <= pc_wb_d;
      pending_q  <= pending_d;
    end
  end

  assign we        = we_q;
  assign wa        = wa_q;
  assign wd        = wd_q;
  assign pc_wb     = pc_wb_q;
  assign busy_mask = pending_q;
  assign q1_busy   = pending_q[q1_addr];
  assign q2_busy   = pending_q[q2_addr];

endmodule
